countdown_timer: RTL

Countdown timer that consumes the 1 Hz `tick` pulse and runs the seconds count in the opposite direction, from a loaded value down to zero. It sits downstream of the free-running seconds counter: it shares that counter's clock, accepts its `tick` strobe, and raises a one-cycle `expired` pulse when the count reaches zero. Control is level-free and pulse-driven: load, start, pause and clear strobes come from the board's button/debounce logic.

---
 rtl/timer_pkg.sv | 14 +
 rtl/countdown_timer.sv | 111 +++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared types for the seconds timing blocks: state encoding of the countdown
// timer and the common seconds bus width.
package timer_pkg;

    localparam int SEC_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Countdown timer driven by the 1 Hz tick strobe: counts a loaded value down to
// zero and pulses expired for one cycle when it gets there.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH       = SEC_W,
    parameter int WARN_THRESH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [WIDTH-1:0] remaining,
    output logic             running,
    output logic             warn,
    output logic             done,
    output logic             expired,
    output timer_state_t     dbg_state
);

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] THRESH = WIDTH'(WARN_THRESH);

    // Handshake note: every control input is a single-cycle strobe sampled at
    // each rising edge; there is no ready/acknowledge, a strobe held high is
    // simply re-evaluated on every edge.

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_remaining;
    logic             r_running;
    logic             r_warn;
    logic             r_done;
    logic             r_expired;

    timer_state_t     w_state_nx;
    logic [WIDTH-1:0] w_remaining_nx;
    logic             w_expired_nx;

    always_comb begin
        w_state_nx     = r_state;
        w_remaining_nx = r_remaining;
        w_expired_nx   = 1'b0;
        if (clear) begin
            w_remaining_nx = '0;
            w_state_nx     = IDLE;
        end else if (load) begin
            w_remaining_nx = load_val;
            w_state_nx     = IDLE;
        end else begin
            case (r_state)
                RUN: begin
                    // A tick reaching zero outranks a simultaneous pause.
                    if (tick) begin
                        w_remaining_nx = r_remaining - ONE;
                        if (r_remaining == ONE) begin
                            w_state_nx   = DONE;
                            w_expired_nx = 1'b1;
                        end else if (pause) begin
                            w_state_nx = PAUSED;
                        end
                    end else if (pause) begin
                        w_state_nx = PAUSED;
                    end
                end
                IDLE: begin
                    if (start && (r_remaining != '0)) begin
                        w_state_nx = RUN;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        w_state_nx = RUN;
                    end
                end
                default: begin
                    w_state_nx = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_running   <= 1'b0;
            r_warn      <= 1'b0;
            r_done      <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_remaining <= w_remaining_nx;
            r_running   <= (w_state_nx == RUN);
            r_warn      <= (w_state_nx == RUN) && (w_remaining_nx <= THRESH);
            r_done      <= (w_state_nx == DONE);
            r_expired   <= w_expired_nx;
        end
    end

    assign remaining = r_remaining;
    assign running   = r_running;
    assign warn      = r_warn;
    assign done      = r_done;
    assign expired   = r_expired;
    assign dbg_state = r_state;

endmodule
